id_ex_ctrl_pipe: RTL and testbench

Parametrised ID-stage decoder plus ID/EX pipeline register for the flow MCU. It decodes the RV32I base subset into a wider control bundle and generates sign-extended immediates. It registers the bundle toward EX and owns load-use hazard detection, downstream backpressure and branch flush. It sits between the IF/ID register and the EX stage, replacing the purely combinational decode step.

---
 rtl/mcu_ctrl_pkg.sv | 64 ++++++
 rtl/id_decode.sv | 108 ++++++++++
 rtl/id_ex_ctrl_pipe.sv | 159 +++++++++++++++
 tb/tb_id_ex_ctrl_pipe.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_ctrl_pkg.sv
// Shared decode definitions for the flow MCU ID stage: opcodes, ALU codes,
// immediate formats and the control bundle carried into EX.
package mcu_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Low 3 bits match the legacy 3-bit encoding for the original ops.
    localparam logic [3:0] ALU_SLL   = 4'b0000;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_AND   = 4'b0011;
    localparam logic [3:0] ALU_OR    = 4'b0100;
    localparam logic [3:0] ALU_XOR   = 4'b0101;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1001;
    localparam logic [3:0] ALU_SLTU  = 4'b1010;
    localparam logic [3:0] ALU_PASSB = 4'b1011;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic [3:0] alu_ctrl;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic       illegal;
    } ctrl_t;

    // SUB exists only for register-register ops; SRA/SRAI both use instr[30].
    function automatic logic [3:0] alu_op(input logic [2:0] funct3,
                                          input logic       alt,
                                          input logic       is_reg);
        logic [3:0] op;
        case (funct3)
            3'b000:  op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/id_decode.sv
// Combinational RV32I-subset decoder: instruction -> control bundle,
// sign-extended immediate and which source registers are really read.
module id_decode
    import mcu_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output ctrl_t           ctrl_o,
    output logic [XLEN-1:0] imm_o,
    output logic            rs1_used_o,
    output logic            rs2_used_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    imm_fmt_e    fmt;
    logic [31:0] imm32;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];

    // NOTE: every output gets a default first so no path through the case can infer a latch.
    always_comb begin
        ctrl_o     = '0;
        fmt        = IMM_I;
        rs1_used_o = 1'b0;
        rs2_used_o = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl_o.alu_ctrl  = alu_op(funct3, instr_i[30], 1'b1);
                ctrl_o.reg_write = 1'b1;
                rs1_used_o       = 1'b1;
                rs2_used_o       = 1'b1;
            end
            OP_IMM: begin
                ctrl_o.alu_ctrl  = alu_op(funct3, instr_i[30], 1'b0);
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                rs1_used_o       = 1'b1;
            end
            OP_LOAD: begin
                if (funct3 == 3'b010) begin
                    ctrl_o.alu_ctrl   = ALU_ADD;
                    ctrl_o.mem_read   = 1'b1;
                    ctrl_o.mem_to_reg = 1'b1;
                    ctrl_o.reg_write  = 1'b1;
                    ctrl_o.alu_src    = 1'b1;
                    rs1_used_o        = 1'b1;
                end else begin
                    ctrl_o.illegal = 1'b1;
                end
            end
            OP_STORE: begin
                fmt = IMM_S;
                if (funct3 == 3'b010) begin
                    ctrl_o.alu_ctrl  = ALU_ADD;
                    ctrl_o.mem_write = 1'b1;
                    ctrl_o.alu_src   = 1'b1;
                    rs1_used_o       = 1'b1;
                    rs2_used_o       = 1'b1;
                end else begin
                    ctrl_o.illegal = 1'b1;
                end
            end
            OP_BRANCH: begin
                fmt = IMM_B;
                if (funct3[2:1] == 2'b00) begin
                    ctrl_o.alu_ctrl = ALU_SUB;
                    ctrl_o.branch   = 1'b1;
                    rs1_used_o      = 1'b1;
                    rs2_used_o      = 1'b1;
                end else begin
                    ctrl_o.illegal = 1'b1;
                end
            end
            OP_LUI: begin
                fmt              = IMM_U;
                ctrl_o.alu_ctrl  = ALU_PASSB;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            OP_JAL: begin
                fmt              = IMM_J;
                ctrl_o.alu_ctrl  = ALU_ADD;
                ctrl_o.jump      = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            default: ctrl_o.illegal = 1'b1;
        endcase
    end

    always_comb begin
        case (fmt)
            IMM_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                              instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U:   imm32 = {instr_i[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                              instr_i[20], instr_i[30:21], 1'b0};
            default: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
        endcase
    end

    // Signed cast widens from bit 31, covering both XLEN=32 and XLEN=64.
    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/id_ex_ctrl_pipe.sv
// ID decode plus ID/EX register with load-use stall, backpressure and flush.
// Optional stall/flush counters are built when ID_EX_CTRL_PERF_EN is defined.
module id_ex_ctrl_pipe
    import mcu_ctrl_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ALU_CTRL_W = 4,
    parameter int REG_AW     = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [31:0]           id_instr,
    input  logic                  ex_ready,
    input  logic                  flush,
    output logic                  stall_o,
    output logic                  ex_valid,
    output logic [ALU_CTRL_W-1:0] ex_alu_ctrl,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_mem_to_reg,
    output logic                  ex_reg_write,
    output logic                  ex_alu_src,
    output logic                  ex_branch,
    output logic                  ex_jump,
    output logic [REG_AW-1:0]     ex_rs1,
    output logic [REG_AW-1:0]     ex_rs2,
    output logic [REG_AW-1:0]     ex_rd,
    output logic [XLEN-1:0]       ex_imm,
    output logic                  ex_illegal,
    output logic                  err_sticky
`ifdef ID_EX_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]      perf_stall_cnt,
    output logic [CNT_W-1:0]      perf_flush_cnt
`endif
);

    ctrl_t             dec_ctrl;
    logic [XLEN-1:0]   dec_imm;
    logic              rs1_used, rs2_used;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    logic              load_use;

    ctrl_t             ex_ctrl_q, ex_ctrl_d;
    logic              ex_valid_q, ex_valid_d;
    logic [REG_AW-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d, ex_rd_q, ex_rd_d;
    logic [XLEN-1:0]   ex_imm_q, ex_imm_d;
    logic              err_q, err_d;

    id_decode #(.XLEN(XLEN)) u_decode (
        .instr_i    (id_instr),
        .ctrl_o     (dec_ctrl),
        .imm_o      (dec_imm),
        .rs1_used_o (rs1_used),
        .rs2_used_o (rs2_used)
    );

    assign id_rs1 = REG_AW'(id_instr[19:15]);
    assign id_rs2 = REG_AW'(id_instr[24:20]);
    assign id_rd  = REG_AW'(id_instr[11:7]);

    assign load_use = ex_valid_q && ex_ctrl_q.mem_read && (ex_rd_q != '0) && id_valid &&
                      ((rs1_used && (id_rs1 == ex_rd_q)) || (rs2_used && (id_rs2 == ex_rd_q)));

    assign stall_o = !rst && !flush && (!ex_ready || load_use);

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_ctrl_d  = ex_ctrl_q;
        ex_rs1_d   = ex_rs1_q;
        ex_rs2_d   = ex_rs2_q;
        ex_rd_d    = ex_rd_q;
        ex_imm_d   = ex_imm_q;
        err_d      = err_q;
        if (flush) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
        end else if (ex_ready) begin
            if (load_use) begin
                ex_valid_d = 1'b0;
                ex_ctrl_d  = '0;
            end else begin
                // Invalid slots enter EX as bubbles so no enable leaks through.
                ex_valid_d = id_valid;
                ex_ctrl_d  = id_valid ? dec_ctrl : '0;
                ex_rs1_d   = id_rs1;
                ex_rs2_d   = id_rs2;
                ex_rd_d    = id_rd;
                ex_imm_d   = dec_imm;
                err_d      = err_q || (id_valid && dec_ctrl.illegal);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
            ex_rd_q    <= '0;
            ex_imm_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_ctrl_q  <= ex_ctrl_d;
            ex_rs1_q   <= ex_rs1_d;
            ex_rs2_q   <= ex_rs2_d;
            ex_rd_q    <= ex_rd_d;
            ex_imm_q   <= ex_imm_d;
            err_q      <= err_d;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_alu_ctrl   = ALU_CTRL_W'(ex_ctrl_q.alu_ctrl);
    assign ex_mem_read   = ex_ctrl_q.mem_read;
    assign ex_mem_write  = ex_ctrl_q.mem_write;
    assign ex_mem_to_reg = ex_ctrl_q.mem_to_reg;
    assign ex_reg_write  = ex_ctrl_q.reg_write;
    assign ex_alu_src    = ex_ctrl_q.alu_src;
    assign ex_branch     = ex_ctrl_q.branch;
    assign ex_jump       = ex_ctrl_q.jump;
    assign ex_illegal    = ex_ctrl_q.illegal;
    assign ex_rs1        = ex_rs1_q;
    assign ex_rs2        = ex_rs2_q;
    assign ex_rd         = ex_rd_q;
    assign ex_imm        = ex_imm_q;
    assign err_sticky    = err_q;

`ifdef ID_EX_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    // Saturating counters: hold at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush && (flush_cnt_q != '1))   flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// Bench for id_ex_ctrl_pipe: decode vector table plus load-use, backpressure,
// flush, illegal and reset sequences; counters checked when ID_EX_CTRL_PERF_EN is set.
module tb_id_ex_ctrl_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_instr;
    logic        ex_ready;
    logic        flush;
    logic        stall_o;
    logic        ex_valid;
    logic [3:0]  ex_alu_ctrl;
    logic        ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write;
    logic        ex_alu_src, ex_branch, ex_jump, ex_illegal, err_sticky;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [31:0] ex_imm;
`ifdef ID_EX_CTRL_PERF_EN
    logic [3:0]  perf_stall_cnt, perf_flush_cnt;
    logic [3:0]  stall_before, flush_before;
`endif

    id_ex_ctrl_pipe #(.XLEN(32), .ALU_CTRL_W(4), .REG_AW(5), .CNT_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_instr      (id_instr),
        .ex_ready      (ex_ready),
        .flush         (flush),
        .stall_o       (stall_o),
        .ex_valid      (ex_valid),
        .ex_alu_ctrl   (ex_alu_ctrl),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_reg_write  (ex_reg_write),
        .ex_alu_src    (ex_alu_src),
        .ex_branch     (ex_branch),
        .ex_jump       (ex_jump),
        .ex_rs1        (ex_rs1),
        .ex_rs2        (ex_rs2),
        .ex_rd         (ex_rd),
        .ex_imm        (ex_imm),
        .ex_illegal    (ex_illegal),
        .err_sticky    (err_sticky)
`ifdef ID_EX_CTRL_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ctl packs {mem_read, mem_write, mem_to_reg, reg_write, alu_src, branch, jump, illegal}
    typedef struct {
        logic        v;
        logic [3:0]  alu;
        logic [7:0]  ctl;
        logic [4:0]  rd;
        logic [31:0] imm;
        bit          chk_data;
        bit          chk_imm;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic        valid;
        exp_t        e;
    } vec_t;

    int   total  = 0;
    int   passed = 0;
    exp_t sb[$];
    vec_t tbl[12];

    localparam logic [31:0] LW5  = 32'h0000A283;  // lw   x5,0(x1)
    localparam logic [31:0] LW6  = 32'h0002A303;  // lw   x6,0(x5)
    localparam logic [31:0] LW0  = 32'h0000A003;  // lw   x0,0(x1)
    localparam logic [31:0] ADD6 = 32'h00228333;  // add  x6,x5,x2
    localparam logic [31:0] ADD7 = 32'h000303B3;  // add  x7,x6,x0
    localparam logic [31:0] ADDZ = 32'h00200333;  // add  x6,x0,x2
    localparam logic [31:0] ADI6 = 32'h00508313;  // addi x6,x1,5 (rs2 field = 5)
    localparam logic [31:0] OR6  = 32'h0020E333;  // or   x6,x1,x2
    localparam logic [31:0] SUB3 = 32'h402081B3;  // sub  x3,x1,x2
    localparam logic [31:0] ILL  = 32'h0000007F;

    function automatic exp_t mk(input logic v, input logic [3:0] alu, input logic [7:0] ctl,
                                input logic [4:0] rd, input logic [31:0] imm,
                                input bit cd, input bit ci);
        exp_t e;
        e.v = v; e.alu = alu; e.ctl = ctl; e.rd = rd; e.imm = imm;
        e.chk_data = cd; e.chk_imm = ci;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic pop_compare(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            $display("FAIL %s: scoreboard empty when output was due", name);
            return;
        end
        e = sb.pop_front();
        check({name, "_valid"}, 64'(ex_valid), 64'(e.v));
        check({name, "_ctl"}, 64'({ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write,
                                   ex_alu_src, ex_branch, ex_jump, ex_illegal}), 64'(e.ctl));
        if (e.chk_data) begin
            check({name, "_alu"}, 64'(ex_alu_ctrl), 64'(e.alu));
            check({name, "_rd"}, 64'(ex_rd), 64'(e.rd));
        end
        if (e.chk_imm) check({name, "_imm"}, 64'(ex_imm), 64'(e.imm));
    endtask

    task automatic step(input logic [31:0] instr, input logic vld, input logic rdy,
                        input logic fl, input exp_t e, input logic exp_stall, input string name);
        @(negedge clk);
        id_instr = instr;
        id_valid = vld;
        ex_ready = rdy;
        flush    = fl;
        sb.push_back(e);
        #1 check({name, "_stall"}, 64'(stall_o), 64'(exp_stall));
        @(posedge clk);
        #1 pop_compare(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t bubble, lw_e, or_e, sub_e;
        bubble = mk(1'b0, 4'h0, 8'h00, 5'd0, 32'h0, 1'b0, 1'b0);
        lw_e   = mk(1'b1, 4'b0010, 8'b10111000, 5'd5, 32'h0, 1'b1, 1'b1);
        or_e   = mk(1'b1, 4'b0100, 8'b00010000, 5'd6, 32'h0, 1'b1, 1'b0);
        sub_e  = mk(1'b1, 4'b0110, 8'b00010000, 5'd3, 32'h0, 1'b1, 1'b0);

        tbl[0]  = '{SUB3,         1'b1, sub_e};
        tbl[1]  = '{32'hFFF00093, 1'b1, mk(1, 4'b0010, 8'b00011000, 5'd1,  32'hFFFFFFFF, 1, 1)};
        tbl[2]  = '{32'h123453B7, 1'b1, mk(1, 4'b1011, 8'b00011000, 5'd7,  32'h12345000, 1, 1)};
        tbl[3]  = '{32'h0020A423, 1'b1, mk(1, 4'b0010, 8'b01001000, 5'd8,  32'h00000008, 1, 1)};
        tbl[4]  = '{32'hFE208EE3, 1'b1, mk(1, 4'b0110, 8'b00000100, 5'd29, 32'hFFFFFFFC, 1, 1)};
        tbl[5]  = '{32'h008000EF, 1'b1, mk(1, 4'b0010, 8'b00010010, 5'd1,  32'h00000008, 1, 1)};
        tbl[6]  = '{32'h4030D213, 1'b1, mk(1, 4'b1001, 8'b00011000, 5'd4,  32'h0, 1, 0)};
        tbl[7]  = '{32'h0020B2B3, 1'b1, mk(1, 4'b1010, 8'b00010000, 5'd5,  32'h0, 1, 0)};
        tbl[8]  = '{LW5,          1'b1, lw_e};
        tbl[9]  = '{ADD6,         1'b0, bubble};
        tbl[10] = '{OR6,          1'b1, or_e};
        tbl[11] = '{32'h0F00F393, 1'b1, mk(1, 4'b0011, 8'b00011000, 5'd7,  32'h000000F0, 1, 1)};

        rst = 1'b1; id_valid = 1'b0; id_instr = '0; ex_ready = 1'b0; flush = 1'b0;
        #12;
        check("rst_valid", 64'(ex_valid), 64'd0);
        check("rst_ctl", 64'({ex_mem_read, ex_mem_write, ex_reg_write, ex_illegal}), 64'd0);
        check("rst_stall", 64'(stall_o), 64'd0);
        check("rst_err", 64'(err_sticky), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++)
            step(tbl[i].instr, tbl[i].valid, 1'b1, 1'b0, tbl[i].e, 1'b0, $sformatf("vec%0d", i));
        check("err_after_table", 64'(err_sticky), 64'd0);

        // Load-use: one bubble, then the dependent add enters EX.
        step(LW5,  1, 1, 0, lw_e,   0, "lu_lw");
        step(ADD6, 1, 1, 0, bubble, 1, "lu_bubble");
        step(ADD6, 1, 1, 0, mk(1, 4'b0010, 8'b00010000, 5'd6, 32'h0, 1, 0), 0, "lu_add");
        // Back-to-back dependent loads: one bubble each.
        step(LW5,  1, 1, 0, lw_e,   0, "b2b_lw5");
        step(LW6,  1, 1, 0, bubble, 1, "b2b_bub1");
        step(LW6,  1, 1, 0, mk(1, 4'b0010, 8'b10111000, 5'd6, 32'h0, 1, 1), 0, "b2b_lw6");
        step(ADD7, 1, 1, 0, bubble, 1, "b2b_bub2");
        step(ADD7, 1, 1, 0, mk(1, 4'b0010, 8'b00010000, 5'd7, 32'h0, 1, 0), 0, "b2b_add");
        // Load to x0 never stalls; an unused rs2 field matching rd never stalls.
        step(LW0,  1, 1, 0, mk(1, 4'b0010, 8'b10111000, 5'd0, 32'h0, 1, 1), 0, "x0_lw");
        step(ADDZ, 1, 1, 0, mk(1, 4'b0010, 8'b00010000, 5'd6, 32'h0, 1, 0), 0, "x0_add");
        step(LW5,  1, 1, 0, lw_e,   0, "unused_lw");
        step(ADI6, 1, 1, 0, mk(1, 4'b0010, 8'b00011000, 5'd6, 32'h5, 1, 1), 0, "unused_addi");

        // Backpressure: three held cycles, then release.
        step(LW5, 1, 1, 0, lw_e, 0, "bp_lw");
        for (int i = 0; i < 3; i++) step(OR6, 1, 0, 0, lw_e, 1, $sformatf("bp_hold%0d", i));
        step(OR6, 1, 1, 0, or_e, 0, "bp_release");
        // Flush in the second held cycle wins over ex_ready=0.
        step(LW5, 1, 1, 0, lw_e,   0, "bpf_lw");
        step(OR6, 1, 0, 0, lw_e,   1, "bpf_hold1");
        step(OR6, 1, 0, 1, bubble, 0, "bpf_flush");
        step(OR6, 1, 0, 0, bubble, 1, "bpf_hold3");
        step(OR6, 1, 1, 0, or_e,   0, "bpf_release");

        // Flush and load-use in the same cycle: flush wins.
        step(LW5, 1, 1, 0, lw_e, 0, "fh_lw");
`ifdef ID_EX_CTRL_PERF_EN
        stall_before = perf_stall_cnt;
        flush_before = perf_flush_cnt;
`endif
        step(ADD6, 1, 1, 1, bubble, 0, "fh_flush");
`ifdef ID_EX_CTRL_PERF_EN
        check("fh_flush_cnt", 64'(perf_flush_cnt), 64'(flush_before + 4'd1));
        check("fh_stall_cnt", 64'(perf_stall_cnt), 64'(stall_before));
`endif

        // Illegal opcode: enables forced off, sticky error stays set.
        step(ILL, 1, 1, 0, mk(1, 4'h0, 8'b00000001, 5'd0, 32'h0, 0, 0), 0, "ill");
        check("ill_err", 64'(err_sticky), 64'd1);
        step(SUB3, 0, 1, 0, bubble, 0, "ill_bubble");
        step(SUB3, 1, 1, 0, sub_e,  0, "ill_sub");
        check("ill_err_sticky", 64'(err_sticky), 64'd1);

        // Async reset in the middle of a stall cycle.
        @(negedge clk);
        ex_ready = 1'b0;
        #1 check("rst_pre_stall", 64'(stall_o), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("arst_valid", 64'(ex_valid), 64'd0);
        check("arst_fields", 64'({ex_alu_ctrl, ex_reg_write, ex_rd, ex_rs1, ex_rs2}), 64'd0);
        check("arst_stall", 64'(stall_o), 64'd0);
        check("arst_err", 64'(err_sticky), 64'd0);
`ifdef ID_EX_CTRL_PERF_EN
        check("arst_cnts", 64'({perf_stall_cnt, perf_flush_cnt}), 64'd0);
`endif
        @(negedge clk);
        rst      = 1'b0;
        ex_ready = 1'b1;
        sb.push_back(sub_e);
        #1 check("post_rst_stall", 64'(stall_o), 64'd0);
        @(posedge clk);
        #1 pop_compare("post_rst_sub");

        // Twenty held cycles: bundle stable, stall counter saturates at 15.
        for (int i = 0; i < 20; i++) step(SUB3, 1, 0, 0, sub_e, 1, $sformatf("sat%0d", i));
`ifdef ID_EX_CTRL_PERF_EN
        check("sat_stall_cnt", 64'(perf_stall_cnt), 64'd15);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
